// File: rtl/tlb_pkg.sv
// Shared defaults, FSM state type and index-width helper for the TLB key CAM.
package tlb_pkg;

  localparam int KEY_WIDTH_DEF = 20;
  localparam int DEPTH_DEF     = 32;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_e;

  // Index width for n entries; never collapses below one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/priority_encoder_n.sv
// Lowest-index priority encoder with any / multiple-hit flags.
module priority_encoder_n import tlb_pkg::*; #(
  parameter  int WIDTH = 32,
  localparam int IW    = idx_w(WIDTH)
) (
  input  logic [WIDTH-1:0] vec_i,
  output logic             any_o,
  output logic [IW-1:0]    idx_o,
  output logic             multi_o
);

  assign any_o   = |vec_i;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi_o = |(vec_i & (vec_i - WIDTH'(1)));

  // Scan from the top so the lowest set bit wins; zero when nothing is set.
  always_comb begin
    idx_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (vec_i[i]) idx_o = IW'(i);
    end
  end

endmodule

// File: rtl/tlb_key_cam.sv
// TLB key store: registered read, write, one-cycle pipelined search,
// sequenced flush and a wired-entry-skipping replacement index.
module tlb_key_cam import tlb_pkg::*; #(
  parameter  int KEY_WIDTH     = KEY_WIDTH_DEF,
  parameter  int DEPTH         = DEPTH_DEF,
  parameter  int FIXED_ENTRIES = 4,
  localparam int INDEX_WIDTH   = idx_w(DEPTH)
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic [INDEX_WIDTH-1:0] accessIndex,
  input  logic                   readEnable,
  output logic [KEY_WIDTH-1:0]   readValue,
  output logic                   readValid,
  input  logic                   writeEnable,
  input  logic [KEY_WIDTH-1:0]   writeValue,
  input  logic                   writeValid,
  input  logic                   searchRequest,
  input  logic [KEY_WIDTH-1:0]   searchKey,
  output logic                   searchDone,
  output logic                   found,
  output logic [INDEX_WIDTH-1:0] foundIndex,
  output logic                   multiMatch,
  input  logic                   flushRequest,
  output logic                   busy,
  output logic [INDEX_WIDTH-1:0] randomIndex
);

  logic [KEY_WIDTH-1:0]   key_q [DEPTH];
  logic [DEPTH-1:0]       valid_q;
  logic [DEPTH-1:0]       match_d, match_q;
  state_e                 state_q, state_d;
  logic [INDEX_WIDTH-1:0] flush_cnt_q, flush_cnt_d;
  logic [INDEX_WIDTH-1:0] rnd_q;
  logic [KEY_WIDTH-1:0]   rd_key_q;
  logic                   rd_vld_q;
  logic                   done_q;
  logic                   wr_en;

  assign busy  = (state_q == FLUSH);
  assign wr_en = writeEnable && !busy;

  // Per-entry compare; a flush in progress masks every hit.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match_d[g] = !busy && valid_q[g] && (key_q[g] == searchKey);
  end

  // Flush sequencer next state: walk the counter from 0 to DEPTH-1.
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (flushRequest) begin
          state_d     = FLUSH;
          flush_cnt_d = '0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + INDEX_WIDTH'(1);
        if (flush_cnt_q == INDEX_WIDTH'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Flush sequencer state register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q     <= IDLE;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Valid bits: writes only when idle, flush clears one entry per cycle.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      valid_q <= '0;
    end else begin
      if (wr_en) valid_q[accessIndex] <= writeValid;
      if (busy)  valid_q[flush_cnt_q] <= 1'b0;
    end
  end

  // Key storage is deliberately unreset; validity alone gates matching.
  always_ff @(posedge clock) begin
    if (wr_en) key_q[accessIndex] <= writeValue;
  end

  // Registered read port; sees pre-write contents on a same-edge write.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rd_key_q <= '0;
      rd_vld_q <= 1'b0;
    end else if (readEnable) begin
      rd_key_q <= key_q[accessIndex];
      rd_vld_q <= valid_q[accessIndex];
    end
  end

  // Search stage: capture the match vector, pulse done one cycle later.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      match_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= searchRequest;
      if (searchRequest) match_q <= match_d;
    end
  end

  // Free-running down counter skipping the wired entries.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      rnd_q <= INDEX_WIDTH'(DEPTH - 1);
    end else if (rnd_q == INDEX_WIDTH'(FIXED_ENTRIES)) begin
      rnd_q <= INDEX_WIDTH'(DEPTH - 1);
    end else begin
      rnd_q <= rnd_q - INDEX_WIDTH'(1);
    end
  end

  priority_encoder_n #(.WIDTH(DEPTH)) u_penc (
    .vec_i   (match_q),
    .any_o   (found),
    .idx_o   (foundIndex),
    .multi_o (multiMatch)
  );

  assign readValue   = rd_key_q;
  assign readValid   = rd_vld_q;
  assign searchDone  = done_q;
  assign randomIndex = rnd_q;

endmodule

// File: tb/tb_tlb_key_cam.sv
// Self-checking bench for tlb_key_cam: table vectors, corner sequences,
// randomized traffic against an array model, flush/reset and random index.
module tb_tlb_key_cam;

  logic        clock;
  logic        resetN;
  logic [4:0]  accessIndex;
  logic        readEnable;
  logic [19:0] readValue;
  logic        readValid;
  logic        writeEnable;
  logic [19:0] writeValue;
  logic        writeValid;
  logic        searchRequest;
  logic [19:0] searchKey;
  logic        searchDone;
  logic        found;
  logic [4:0]  foundIndex;
  logic        multiMatch;
  logic        flushRequest;
  logic        busy;
  logic [4:0]  randomIndex;

  // Small instance for the wired-entry random index check.
  logic        rst8N;
  logic [2:0]  idx8;
  logic [19:0] zkey8;
  logic        z8;
  logic [19:0] r8_rv;
  logic        r8_rvld, r8_done, r8_f, r8_mm, r8_busy;
  logic [2:0]  r8_fi, r8_rnd;

  tlb_key_cam dut (
    .clock(clock), .resetN(resetN), .accessIndex(accessIndex),
    .readEnable(readEnable), .readValue(readValue), .readValid(readValid),
    .writeEnable(writeEnable), .writeValue(writeValue), .writeValid(writeValid),
    .searchRequest(searchRequest), .searchKey(searchKey), .searchDone(searchDone),
    .found(found), .foundIndex(foundIndex), .multiMatch(multiMatch),
    .flushRequest(flushRequest), .busy(busy), .randomIndex(randomIndex)
  );

  tlb_key_cam #(.DEPTH(8), .FIXED_ENTRIES(3)) dut8 (
    .clock(clock), .resetN(rst8N), .accessIndex(idx8),
    .readEnable(z8), .readValue(r8_rv), .readValid(r8_rvld),
    .writeEnable(z8), .writeValue(zkey8), .writeValid(z8),
    .searchRequest(z8), .searchKey(zkey8), .searchDone(r8_done),
    .found(r8_f), .foundIndex(r8_fi), .multiMatch(r8_mm),
    .flushRequest(z8), .busy(r8_busy), .randomIndex(r8_rnd)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: contents, validity, whether the key is known, counters.
  logic [19:0] m_key   [32];
  bit          m_val   [32];
  bit          m_known [32];
  int          m_rnd  = 31;
  int          m_rnd8 = 7;

  typedef struct {
    bit          we;
    int          idx;
    logic [19:0] wkey;
    bit          wvld;
    logic [19:0] skey;
    bit          f;
    int          fi;
    bit          mm;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    m_rnd  = (!resetN || m_rnd == 4) ? 31 : m_rnd - 1;
    m_rnd8 = (!rst8N || m_rnd8 == 3) ? 7 : m_rnd8 - 1;
  endtask

  function automatic void mwrite(input int i, input logic [19:0] k, input bit v);
    m_key[i] = k; m_val[i] = v; m_known[i] = 1'b1;
  endfunction

  function automatic void msearch(input logic [19:0] k, output bit f, output int ix, output bit mm);
    int n;
    n = 0; ix = 0;
    for (int i = 0; i < 32; i++) begin
      if (m_val[i] && m_key[i] == k) begin
        if (n == 0) ix = i;
        n++;
      end
    end
    f = (n > 0); mm = (n > 1);
  endfunction

  task automatic do_write(input int i, input logic [19:0] k, input bit v);
    accessIndex = 5'(i); writeEnable = 1'b1; writeValue = k; writeValid = v;
    tick();
    writeEnable = 1'b0;
    mwrite(i, k, v);
  endtask

  task automatic do_search(input logic [19:0] k);
    searchRequest = 1'b1; searchKey = k;
    tick();
    searchRequest = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] pool [4];
    bit   sr, re, we, wv, hf, hm, hrk, hrv_vld;
    int   idx, hi, busy_cnt, bad;
    logic [19:0] wk, sk, hrv;

    pool[0] = 20'h0AAAA; pool[1] = 20'h0BBBB; pool[2] = 20'h12345; pool[3] = 20'hABCDE;
    for (int i = 0; i < 32; i++) begin m_val[i] = 0; m_known[i] = 0; m_key[i] = '0; end

    tbl[0] = '{0, 0,  20'h00000, 0, 20'h00000, 0, 0,  0};
    tbl[1] = '{1, 7,  20'hABCDE, 1, 20'hABCDE, 1, 7,  0};
    tbl[2] = '{1, 20, 20'h12345, 1, 20'h12345, 1, 20, 0};
    tbl[3] = '{1, 5,  20'h12345, 1, 20'h12345, 1, 5,  1};
    tbl[4] = '{1, 5,  20'h12345, 0, 20'h12345, 1, 20, 0};
    tbl[5] = '{1, 20, 20'h12345, 0, 20'h12345, 0, 0,  0};
    tbl[6] = '{1, 0,  20'h00000, 1, 20'h00000, 1, 0,  0};
    tbl[7] = '{1, 31, 20'hFFFFF, 1, 20'hFFFFF, 1, 31, 0};
    tbl[8] = '{1, 30, 20'h00000, 1, 20'h00000, 1, 0,  1};

    resetN = 1'b0; rst8N = 1'b0;
    accessIndex = '0; readEnable = 0; writeEnable = 0; writeValue = '0; writeValid = 0;
    searchRequest = 0; searchKey = '0; flushRequest = 0;
    idx8 = '0; zkey8 = '0; z8 = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_readValue", readValue, 0);
    chk("rst_readValid", readValid, 0);
    chk("rst_searchDone", searchDone, 0);
    chk("rst_found", found, 0);
    chk("rst_foundIndex", foundIndex, 0);
    chk("rst_multiMatch", multiMatch, 0);
    chk("rst_busy", busy, 0);
    chk("rst_randomIndex", randomIndex, 31);
    resetN = 1'b1;

    // Table vectors: optional write, then a search on the following edge
    for (int v = 0; v < 9; v++) begin
      if (tbl[v].we) do_write(tbl[v].idx, tbl[v].wkey, tbl[v].wvld);
      do_search(tbl[v].skey);
      chk($sformatf("tbl%0d_done", v), searchDone, 1);
      chk($sformatf("tbl%0d_found", v), found, tbl[v].f);
      chk($sformatf("tbl%0d_idx", v), foundIndex, tbl[v].fi);
      chk($sformatf("tbl%0d_multi", v), multiMatch, tbl[v].mm);
    end

    // Same-edge write and search: search sees old contents
    accessIndex = 5'd9; writeEnable = 1; writeValue = 20'h55555; writeValid = 1;
    searchRequest = 1; searchKey = 20'h55555;
    tick();
    writeEnable = 0; searchRequest = 0; mwrite(9, 20'h55555, 1);
    chk("same_edge_done", searchDone, 1);
    chk("same_edge_found", found, 0);
    do_search(20'h55555);
    chk("after_write_found", found, 1);
    chk("after_write_idx", foundIndex, 9);
    tick();
    chk("done_pulse", searchDone, 0);
    chk("found_held", found, 1);
    chk("idx_held", foundIndex, 9);

    // Same-edge write and read of one index returns the old key
    accessIndex = 5'd7; readEnable = 1; writeEnable = 1; writeValue = 20'h11111; writeValid = 1;
    tick();
    writeEnable = 0;
    chk("rw_same_old", readValue, 20'hABCDE);
    chk("rw_same_vld", readValid, 1);
    tick();
    readEnable = 0; mwrite(7, 20'h11111, 1);
    chk("rw_new", readValue, 20'h11111);
    hrv = 20'h11111; hrv_vld = 1; hrk = 1; hf = 0; hi = 0; hm = 0;

    // Randomized traffic against the model
    for (int c = 0; c < 400; c++) begin
      we  = ($urandom_range(0, 2) == 0);
      idx = $urandom_range(0, 31);
      wk  = pool[$urandom_range(0, 3)];
      wv  = ($urandom_range(0, 3) != 0);
      sr  = (c == 0) || ($urandom_range(0, 1) == 1);
      sk  = pool[$urandom_range(0, 3)];
      re  = ($urandom_range(0, 2) == 0);
      if (sr) msearch(sk, hf, hi, hm);
      if (re) begin hrv = m_key[idx]; hrv_vld = m_val[idx]; hrk = m_known[idx]; end
      accessIndex = 5'(idx); writeEnable = we; writeValue = wk; writeValid = wv;
      searchRequest = sr; searchKey = sk; readEnable = re;
      tick();
      writeEnable = 0; searchRequest = 0; readEnable = 0;
      if (we) mwrite(idx, wk, wv);
      chk($sformatf("rnd%0d_done", c), searchDone, sr);
      chk($sformatf("rnd%0d_found", c), found, hf);
      chk($sformatf("rnd%0d_idx", c), foundIndex, hi);
      chk($sformatf("rnd%0d_multi", c), multiMatch, hm);
      chk($sformatf("rnd%0d_rvld", c), readValid, hrv_vld);
      if (hrk) chk($sformatf("rnd%0d_rval", c), readValue, hrv);
      chk($sformatf("rnd%0d_ridx", c), randomIndex, m_rnd);
    end

    // Flush: fill everything, busy exactly 32 cycles, mid-flush write/search
    for (int i = 0; i < 32; i++) do_write(i, 20'h10000 + 20'(i), 1);
    flushRequest = 1;
    tick();
    flushRequest = 0;
    busy_cnt = 0;
    for (int c = 0; c < 200 && busy; c++) begin
      busy_cnt++;
      if (c == 10) begin
        accessIndex = 5'd3; writeEnable = 1; writeValue = 20'h77777; writeValid = 1;
        searchRequest = 1; searchKey = 20'h10019;
      end
      tick();
      writeEnable = 0; searchRequest = 0;
      if (c == 10) begin
        chk("flush_srch_done", searchDone, 1);
        chk("flush_srch_found", found, 0);
        chk("flush_srch_idx", foundIndex, 0);
        chk("flush_srch_multi", multiMatch, 0);
      end
    end
    chk("flush_busy_cycles", busy_cnt, 32);
    for (int i = 0; i < 32; i++) m_val[i] = 0;
    for (int i = 0; i < 32; i++) begin
      accessIndex = 5'(i); readEnable = 1;
      tick();
      chk($sformatf("flush_rvld%0d", i), readValid, 0);
      if (i == 3) chk("flush_write_dropped", readValue, 20'h10003);
    end
    readEnable = 0;
    do_write(3, 20'h77777, 1);
    accessIndex = 5'd3; readEnable = 1;
    tick();
    readEnable = 0;
    chk("post_flush_wr_vld", readValid, 1);
    chk("post_flush_wr_val", readValue, 20'h77777);

    // Write together with flushRequest in IDLE: write lands, flush clears it
    accessIndex = 5'd4; writeEnable = 1; writeValue = 20'h44444; writeValid = 1; flushRequest = 1;
    tick();
    writeEnable = 0; flushRequest = 0;
    for (int c = 0; c < 100 && busy; c++) tick();
    chk("wr_flush_idle", busy, 0);
    for (int i = 0; i < 32; i++) m_val[i] = 0;
    accessIndex = 5'd4; readEnable = 1;
    tick();
    readEnable = 0;
    chk("wr_flush_val", readValue, 20'h44444);
    chk("wr_flush_vld", readValid, 0);

    // Reset in the middle of a flush, one cycle after a search request
    do_write(31, 20'h0BEEF, 1);
    flushRequest = 1;
    tick();
    flushRequest = 0;
    repeat (8) tick();
    do_search(20'h0BEEF);
    chk("pre_rst_done", searchDone, 1);
    chk("pre_rst_busy", busy, 1);
    #2;
    resetN = 1'b0;
    #1;
    chk("midrst_busy", busy, 0);
    chk("midrst_done", searchDone, 0);
    chk("midrst_found", found, 0);
    chk("midrst_ridx", randomIndex, 31);
    tick();
    chk("midrst_ridx_held", randomIndex, 31);
    resetN = 1'b1;
    for (int i = 0; i < 32; i++) m_val[i] = 0;
    do_search(20'h0BEEF);
    chk("postrst_found", found, 0);
    chk("postrst_ridx", randomIndex, m_rnd);

    // DEPTH=8, FIXED_ENTRIES=3 replacement index sequence
    chk("rnd8_reset", r8_rnd, 7);
    rst8N = 1'b1;
    bad = 0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      chk($sformatf("rnd8_seq%0d", c), r8_rnd, m_rnd8);
      if (r8_rnd < 3) bad++;
    end
    chk("rnd8_range", bad, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tlb_key_cam.md
# tlb_key_cam

Parametrised content-addressable key store for the ECO32 TLB, successor to the fixed 32×20 key memory. Holds DEPTH page-number keys, each with a valid bit, and supports registered read, synchronous write, a one-cycle-latency pipelined search with lowest-index priority and multi-match detection, a sequenced invalidate-all (flush), and a random-replacement index generator that skips the fixed (wired) entries. Sits between the MMU control FSM and the TLB frame memory.

## Interface
- KEY_WIDTH, 20, key (virtual page number) width
- DEPTH, 32, number of entries; power of two, ≥ 4
- FIXED_ENTRIES, 4, entries 0..FIXED_ENTRIES-1 are never produced by the random index; 0 ≤ FIXED_ENTRIES < DEPTH
- INDEX_WIDTH, $clog2(DEPTH), derived; not overridden
---
- clock  in  1  single clock, all state on rising edge
- resetN  in  1  reset, asynchronous, active-low
- accessIndex  in  INDEX_WIDTH  entry to read or write
- readEnable  in  1  capture entry accessIndex into read outputs
- readValue  out  KEY_WIDTH  registered key of last read
- readValid  out  1  registered valid bit of last read
- writeEnable  in  1  write entry accessIndex
- writeValue  in  KEY_WIDTH  key to write
- writeValid  in  1  valid bit to write
- searchRequest  in  1  start a search this cycle
- searchKey  in  KEY_WIDTH  key to search for
- searchDone  out  1  one-cycle pulse: search result valid
- found  out  1  some valid entry matched
- foundIndex  out  INDEX_WIDTH  lowest matching index; 0 when !found
- multiMatch  out  1  two or more valid entries matched
- flushRequest  in  1  start invalidate-all
- busy  out  1  flush in progress
- randomIndex  out  INDEX_WIDTH  replacement index, always in FIXED_ENTRIES..DEPTH-1

## Operation
- Storage: DEPTH keys (not reset) plus DEPTH valid bits (reset to 0).
- Match for entry i: valid[i] && key[i] == searchKey. Invalid entries never match, regardless of key contents.
- Search: inputs sampled at request edge. Match vector is registered and then priority-encoded. found, foundIndex and multiMatch are held until the next searchDone.
- Write: at the edge with writeEnable && !busy, key[accessIndex] ← writeValue and valid[accessIndex] ← writeValid.
- Read: at the edge with readEnable, readValue ← key[accessIndex] and readValid ← valid[accessIndex]. Both hold otherwise.
- FSM, two states:
  - IDLE → FLUSH on flushRequest; clears flushCounter to 0.
  - FLUSH: clears valid[flushCounter] each cycle and increments the counter. Returns to IDLE after clearing entry DEPTH-1.
  - busy = (state == FLUSH).
- While busy:
  - writes are dropped;
  - flushRequest is ignored;
  - searches still complete but return found=0, multiMatch=0, foundIndex=0;
  - reads are serviced normally.
- randomIndex: decrements every cycle. From FIXED_ENTRIES it wraps to DEPTH-1. Reset value is DEPTH-1. It never pauses.
- Reset values: readValue 0, readValid 0, searchDone 0, found 0, foundIndex 0, multiMatch 0, busy 0, randomIndex DEPTH-1, all valid bits 0.

## Timing
- Search latency: request at edge N → searchDone=1 during cycle N+1. Back-to-back requests give one result per cycle.
- Same-edge write and search: the search sees the old contents. A search at N+1 sees the write.
- Same-edge write and read of the same index: read returns the old value.
- Flush: flushRequest at edge N → busy=1 from N+1 through N+DEPTH → busy=0 at N+DEPTH+1. Writes are accepted again at that edge.
- flushRequest together with writeEnable in IDLE: the write happens, then the flush clears it.
- A flush in progress does not cancel the search result already in flight.
- resetN asserted mid-flush or mid-search:
  - immediately returns to IDLE;
  - clears all valid bits;
  - forces the reset output values above;
  - drops the pending searchDone.

## Structure
- Package tlb_pkg: default KEY_WIDTH and DEPTH, FSM state enum (IDLE, FLUSH), index-width helper function.
- Sub-module priority_encoder_n (parameter WIDTH):
  - inputs: match vector;
  - outputs: any, lowest index, multiple (vector has more than one bit set, i.e. v & (v-1) ≠ 0).

## Test plan
- Reset, then search key 0x00000 → searchDone one cycle later with found=0. Keys are unreset, and this confirms that invalid entries never match.
- Write 0xABCDE valid to index 7, search 0xABCDE at the next cycle → found=1, foundIndex=7, multiMatch=0. Repeat the search on the same edge as the write → found=0.
- Write 0x12345 valid to indices 20 and 5 → search 0x12345 gives foundIndex=5, multiMatch=1. Write index 5 with writeValid=0 → foundIndex=20, multiMatch=0.
- Fill all 32 entries valid, pulse flushRequest → busy high exactly 32 cycles. A write and a search mid-flush are dropped and return found=0 respectively. After busy falls, every entry reads readValid=0.
- DEPTH=8, FIXED_ENTRIES=3:
  - reset → randomIndex sequence 7,6,5,4,3,7,6,…
  - values 0–2 never appear over 1000 cycles.
- Assert resetN at cycle 10 of a flush and in the cycle after a searchRequest → busy=0 and searchDone=0 immediately. randomIndex=DEPTH-1 while reset is held.
